// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed common-anode 7-segment scan driver
module seg_scan_display #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   dig_en,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blink,
    input  logic                lz_blank,
    output logic [6:0]          seg,
    output logic                dp_n,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       index_q, index_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic                blink_phase_q, blink_phase_d;
    logic                wrap_q, wrap_d;

    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   dig_en_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   blink_q;

    logic [6:0]          seg_d;
    logic                dp_n_d;
    logic [DIGITS-1:0]   an_d;

    logic                presc_last;
    logic                idx_last;
    logic                frame_wrap;
    logic [3:0]          cur_nib;
    logic [IW-1:0]       lead_idx;
    logic                blank;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        presc_last    = (presc_q == PRESC_LAST);
        idx_last      = (index_q == IDX_LAST);
        frame_wrap    = presc_last && idx_last;
        presc_d       = presc_last ? '0 : presc_q + 1'b1;
        index_d       = index_q;
        frame_d       = frame_q;
        blink_phase_d = blink_phase_q;
        wrap_d        = frame_wrap;
        if (presc_last) begin
            index_d = idx_last ? '0 : index_q + 1'b1;
        end
        if (frame_wrap) begin
            if (frame_q == FRAME_LAST) begin
                frame_d       = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // Leading-zero scan looks at shadow data only; dig_en does not hide a nonzero digit.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (data_q[4*i +: 4] != 4'h0) begin
                lead_idx = IW'(i);
            end
        end
    end

    always_comb begin
        cur_nib = data_q[{index_q, 2'b00} +: 4];
        blank   = (presc_q == '0)
               || !en
               || !dig_en_q[index_q]
               || (blink_q[index_q] && blink_phase_q)
               || (lz_blank && (index_q > lead_idx) && (index_q != '0));
        an_d    = blank ? '1 : ~(DIGITS'(1) << index_q);
        seg_d   = blank ? 7'h7F : decode(cur_nib);
        dp_n_d  = blank ? 1'b1 : ~dp_q[index_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            index_q       <= '0;
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
            wrap_q        <= 1'b0;
            data_q        <= '0;
            dig_en_q      <= '0;
            dp_q          <= '0;
            blink_q       <= '0;
        end else begin
            presc_q       <= presc_d;
            index_q       <= index_d;
            frame_q       <= frame_d;
            blink_phase_q <= blink_phase_d;
            wrap_q        <= wrap_d;
            if (load) begin
                data_q   <= data;
                dig_en_q <= dig_en;
                dp_q     <= dp;
                blink_q  <= blink;
            end
        end
    end

    // Outputs lag the counters by one clock, so the wrap flag lands on the slot-0 guard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= '1;
            seg        <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            dp_n       <= dp_n_d;
            frame_done <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - directed self-checking bench for seg_scan_display
module tb_seg_scan_display;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dig_en;
    logic [3:0]  dp;
    logic [3:0]  blink;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] cap_an  [16];
    logic [6:0] cap_seg [16];
    logic       cap_dp  [16];
    logic       cap_fd  [16];

    seg_scan_display #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data       (data),
        .dig_en     (dig_en),
        .dp         (dp),
        .blink      (blink),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_load(input logic [15:0] d, input logic [3:0] de,
                           input logic [3:0] p, input logic [3:0] b);
        data   = d;
        dig_en = de;
        dp     = p;
        blink  = b;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_frame_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture_frame(output bit ok);
        wait_frame_done(ok);
        if (ok) begin
            for (int k = 0; k < 16; k++) begin
                if (k > 0) @(negedge clk);
                cap_an[k]  = an;
                cap_seg[k] = seg;
                cap_dp[k]  = dp_n;
                cap_fd[k]  = frame_done;
            end
        end
    endtask

    task automatic release_and_measure(output int cycles, output bit all_blank);
        rst       = 1'b0;
        cycles    = 0;
        all_blank = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (an !== 4'hF) all_blank = 1'b0;
            if (frame_done === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        int cycles;
        bit all_blank;
        @(negedge clk);
        n_checks++;
        if ({an, seg, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs got an=%h seg=%h dp_n=%b fd=%b exp an=f seg=7f dp_n=1 fd=0",
                     an, seg, dp_n, frame_done);
        end
        release_and_measure(cycles, all_blank);
        n_checks++;
        if (cycles != 17) begin
            n_fail++;
            $display("FAIL reset_first_frame_done got %0d cycles exp 17", cycles);
        end
        n_checks++;
        if (!all_blank) begin
            n_fail++;
            $display("FAIL reset_shadows_blank got a lit digit exp all an=f");
        end
    endtask

    task automatic test_basic;
        bit ok;
        logic [6:0] es [4];
        logic [3:0] ea;
        logic [6:0] eseg;
        bit fd_clean;
        es = '{7'h0E, 7'h08, 7'h24, 7'h79};
        do_load(16'h12AF, 4'hF, 4'h0, 4'h0);
        capture_frame(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_sync got no frame_done exp pulse within 40 clocks");
        end
        for (int k = 0; k < 16; k++) begin
            ea   = (k % 4 == 0) ? 4'hF : ~(4'b0001 << (k / 4));
            eseg = (k % 4 == 0) ? 7'h7F : es[k / 4];
            n_checks++;
            if ({cap_an[k], cap_seg[k], cap_dp[k]} !== {ea, eseg, 1'b1}) begin
                n_fail++;
                $display("FAIL basic_slot k=%0d got an=%h seg=%h dp_n=%b exp an=%h seg=%h dp_n=1",
                         k, cap_an[k], cap_seg[k], cap_dp[k], ea, eseg);
            end
        end
        fd_clean = 1'b1;
        for (int k = 1; k < 16; k++) if (cap_fd[k] !== 1'b0) fd_clean = 1'b0;
        n_checks++;
        if (!fd_clean) begin
            n_fail++;
            $display("FAIL basic_fd_width got extra frame_done high exp single pulse");
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_fd_period got fd=%b at clock 16 exp 1", frame_done);
        end
    endtask

    task automatic test_lz_blank;
        bit ok;
        bit lit [4];
        logic [6:0] es [4];
        logic [3:0] ea;
        logic [6:0] eseg;
        lz_blank = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                do_load(16'h0050, 4'hF, 4'h0, 4'h0);
                lit = '{1'b1, 1'b1, 1'b0, 1'b0};
                es  = '{7'h40, 7'h12, 7'h7F, 7'h7F};
            end else begin
                do_load(16'h0000, 4'hF, 4'h0, 4'h0);
                lit = '{1'b1, 1'b0, 1'b0, 1'b0};
                es  = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
            end
            capture_frame(ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL lz_sync pass=%0d got no frame_done exp pulse", pass);
            end
            for (int k = 0; k < 16; k++) begin
                ea   = (k % 4 == 0 || !lit[k / 4]) ? 4'hF : ~(4'b0001 << (k / 4));
                eseg = (k % 4 == 0 || !lit[k / 4]) ? 7'h7F : es[k / 4];
                n_checks++;
                if ({cap_an[k], cap_seg[k], cap_dp[k]} !== {ea, eseg, 1'b1}) begin
                    n_fail++;
                    $display("FAIL lz_slot pass=%0d k=%0d got an=%h seg=%h dp_n=%b exp an=%h seg=%h dp_n=1",
                             pass, k, cap_an[k], cap_seg[k], cap_dp[k], ea, eseg);
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_dp_dig_en;
        bit ok;
        bit lit [4];
        logic [6:0] es [4];
        logic [3:0] ea;
        logic [6:0] eseg;
        logic edp;
        lit = '{1'b1, 1'b0, 1'b1, 1'b1};
        es  = '{7'h0E, 7'h08, 7'h24, 7'h79};
        do_load(16'h12AF, 4'b1101, 4'b0100, 4'h0);
        capture_frame(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dp_sync got no frame_done exp pulse");
        end
        for (int k = 0; k < 16; k++) begin
            ea   = (k % 4 == 0 || !lit[k / 4]) ? 4'hF : ~(4'b0001 << (k / 4));
            eseg = (k % 4 == 0 || !lit[k / 4]) ? 7'h7F : es[k / 4];
            edp  = (k % 4 != 0 && k / 4 == 2) ? 1'b0 : 1'b1;
            n_checks++;
            if ({cap_an[k], cap_seg[k], cap_dp[k]} !== {ea, eseg, edp}) begin
                n_fail++;
                $display("FAIL dp_slot k=%0d got an=%h seg=%h dp_n=%b exp an=%h seg=%h dp_n=%b",
                         k, cap_an[k], cap_seg[k], cap_dp[k], ea, eseg, edp);
            end
        end
    endtask

    task automatic test_enable;
        bit ok;
        bit all_blank;
        do_load(16'h12AF, 4'hF, 4'h0, 4'h0);
        wait_frame_done(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL en_sync got no frame_done exp pulse");
        end
        repeat (5) @(negedge clk);
        en = 1'b0;
        all_blank = 1'b1;
        for (int k = 6; k < 16; k++) begin
            @(negedge clk);
            if ({an, seg, dp_n} !== {4'hF, 7'h7F, 1'b1}) all_blank = 1'b0;
        end
        n_checks++;
        if (!all_blank) begin
            n_fail++;
            $display("FAIL en_blank got lit output while en=0 exp all blank");
        end
        en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({frame_done, an} !== {1'b1, 4'hF}) begin
            n_fail++;
            $display("FAIL en_phase got fd=%b an=%h exp fd=1 an=f", frame_done, an);
        end
        @(negedge clk);
        n_checks++;
        if ({an, seg} !== {4'hE, 7'h0E}) begin
            n_fail++;
            $display("FAIL en_resume got an=%h seg=%h exp an=e seg=0e", an, seg);
        end
    endtask

    task automatic test_blink;
        bit ok;
        bit lit [4];
        lit = '{1'b1, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_load(16'h12AF, 4'hF, 4'h0, 4'b0001);
        for (int f = 0; f < 4; f++) begin
            capture_frame(ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL blink_sync f=%0d got no frame_done exp pulse", f);
            end
            n_checks++;
            if ({cap_an[2], cap_seg[2]} !== (lit[f] ? {4'hE, 7'h0E} : {4'hF, 7'h7F})) begin
                n_fail++;
                $display("FAIL blink_digit0 f=%0d got an=%h seg=%h exp lit=%b",
                         f, cap_an[2], cap_seg[2], lit[f]);
            end
            n_checks++;
            if ({cap_an[6], cap_seg[6]} !== {4'hD, 7'h08}) begin
                n_fail++;
                $display("FAIL blink_digit1 f=%0d got an=%h seg=%h exp an=d seg=08",
                         f, cap_an[6], cap_seg[6]);
            end
        end
    endtask

    task automatic test_rst_mid;
        bit ok;
        int cycles;
        bit all_blank;
        do_load(16'h12AF, 4'hF, 4'h0, 4'h0);
        wait_frame_done(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_sync got no frame_done exp pulse");
        end
        repeat (9) @(negedge clk);
        n_checks++;
        if (an !== 4'hB) begin
            n_fail++;
            $display("FAIL rst_pre got an=%h exp b", an);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({an, seg, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_async got an=%h seg=%h dp_n=%b fd=%b exp an=f seg=7f dp_n=1 fd=0",
                     an, seg, dp_n, frame_done);
        end
        @(negedge clk);
        @(negedge clk);
        release_and_measure(cycles, all_blank);
        n_checks++;
        if (cycles != 17) begin
            n_fail++;
            $display("FAIL rst_restart got %0d cycles to frame_done exp 17", cycles);
        end
        n_checks++;
        if (!all_blank) begin
            n_fail++;
            $display("FAIL rst_shadows got a lit digit exp all an=f");
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        load     = 1'b0;
        data     = '0;
        dig_en   = '0;
        dp       = '0;
        blink    = '0;
        lz_blank = 1'b0;
        test_reset;
        test_basic;
        test_lz_blank;
        test_dp_dig_en;
        test_enable;
        test_blink;
        test_rst_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish before 200000");
        $fatal(1);
    end

endmodule
